skid_pipe_reg: RTL and testbench

SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

---
 rtl/skid_pipe_reg.sv | 106 ++++++++++
 tb/tb_skid_pipe_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe_reg.sv
// Two-entry skid buffer between a valid/ready producer and consumer, with a registered
// in_ready, synchronous flush, and a saturating counter of downstream stall cycles.
module skid_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  assign w_stall     = w_out_valid & ~out_ready;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      // The stall counter keeps counting through a flush; only Clr clears it.
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);

      if (Flush) begin
        r_state    <= S_EMPTY;
        r_main     <= '0;
        r_skid     <= '0;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_in_fire) begin
              r_main  <= in_data;
              r_state <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= in_data;
            end else if (w_in_fire) begin
              // Downstream stalled: park the new word and drop in_ready next cycle.
              r_skid     <= in_data;
              r_state    <= S_FULL;
              r_in_ready <= 1'b0;
            end else if (w_out_fire) begin
              r_main  <= '0;
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_out_fire) begin
              r_main     <= r_skid;
              r_skid     <= '0;
              r_state    <= S_ONE;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Directed and scoreboarded bench for skid_pipe_reg; a second instance with CNT_W=2
// exercises stall counter saturation.
module tb_skid_pipe_reg;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  logic          clr2, in_valid2, out_ready2;
  logic [DW-1:0] in_data2;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [1:0]    stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skid_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .Clk(clk), .Clr(clr), .Flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  skid_pipe_reg #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .Clk(clk), .Clr(clr2), .Flush(1'b0),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
    .stall_cnt(stall_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clr2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    tick();
    tick();
    clr = 1'b0; clr2 = 1'b0;
    checks++;
    if ({out_valid, out_data, in_ready, stall_cnt} !== {1'b0, 8'h00, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h rdy=%b cnt=%0d, want v=0 d=00 rdy=1 cnt=0",
               out_valid, out_data, in_ready, stall_cnt);
    end
    checks++;
    if ({out_valid2, out_data2, in_ready2, stall_cnt2} !== {1'b0, 8'h00, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset2: got v=%b d=%h rdy=%b cnt=%0d, want v=0 d=00 rdy=1 cnt=0",
               out_valid2, out_data2, in_ready2, stall_cnt2);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '0;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h, want v=1 d=a5", out_valid, out_data);
    end
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_drain: got v=%b d=%h, want v=0 d=00", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      checks++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'(i), 1'b1}) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b d=%h rdy=%b, want v=1 d=%h rdy=1",
                 i, out_valid, out_data, in_ready, 8'(i));
      end
    end
    in_valid = 1'b0; in_data = '0;
    tick();
    checks++;
    if ({out_valid, out_data, stall_cnt} !== {1'b0, 8'h00, 16'd0}) begin
      errors++;
      $display("FAIL stream_end: got v=%b d=%h cnt=%0d, want v=0 d=00 cnt=0",
               out_valid, out_data, stall_cnt);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();                      // EMPTY -> ONE, no stall counted yet
    in_data = 8'h22;
    tick();                      // ONE stalled: cnt 1, skid takes 0x22
    in_valid = 1'b0; in_data = '0;
    checks++;
    if ({out_valid, out_data, in_ready, stall_cnt} !== {1'b1, 8'h11, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL stall_full: got v=%b d=%h rdy=%b cnt=%0d, want v=1 d=11 rdy=0 cnt=1",
               out_valid, out_data, in_ready, stall_cnt);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({out_data, in_ready, stall_cnt} !== {8'h11, 1'b0, 16'd5}) begin
      errors++;
      $display("FAIL stall_hold: got d=%h rdy=%b cnt=%0d, want d=11 rdy=0 cnt=5",
               out_data, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    tick();                      // 0x11 delivered
    checks++;
    if ({out_valid, out_data, in_ready, stall_cnt} !== {1'b1, 8'h22, 1'b1, 16'd5}) begin
      errors++;
      $display("FAIL stall_drain1: got v=%b d=%h rdy=%b cnt=%0d, want v=1 d=22 rdy=1 cnt=5",
               out_valid, out_data, in_ready, stall_cnt);
    end
    tick();                      // 0x22 delivered
    checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL stall_drain2: got v=%b d=%h rdy=%b, want v=0 d=00 rdy=1",
               out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();                      // cnt stays 5
    in_data = 8'h22;
    tick();                      // stalled in ONE: cnt 6, now FULL
    checks++;
    if ({in_ready, stall_cnt} !== {1'b0, 16'd6}) begin
      errors++;
      $display("FAIL flush_pre: got rdy=%b cnt=%0d, want rdy=0 cnt=6", in_ready, stall_cnt);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    checks++;
    if ({out_valid, out_data, in_ready, stall_cnt} !== {1'b0, 8'h00, 1'b1, 16'd6}) begin
      errors++;
      $display("FAIL flush: got v=%b d=%h rdy=%b cnt=%0d, want v=0 d=00 rdy=1 cnt=6",
               out_valid, out_data, in_ready, stall_cnt);
    end
    tick();
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL flush_no33: got v=%b d=%h, want v=0 d=00", out_valid, out_data);
    end
  endtask

  task automatic test_saturate();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 8'h5A;
    tick();
    in_valid2 = 1'b0; in_data2 = '0;
    tick();
    tick();
    checks++;
    if (stall_cnt2 !== 2'd2) begin
      errors++;
      $display("FAIL sat_count: got cnt=%0d, want cnt=2", stall_cnt2);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({out_valid2, out_data2, stall_cnt2} !== {1'b1, 8'h5A, 2'd3}) begin
      errors++;
      $display("FAIL sat_hold: got v=%b d=%h cnt=%0d, want v=1 d=5a cnt=3",
               out_valid2, out_data2, stall_cnt2);
    end
  endtask

  task automatic test_clr_priority();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    clr = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
    tick();
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    checks++;
    if ({out_valid, out_data, in_ready, stall_cnt} !== {1'b0, 8'h00, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL clr_prio: got v=%b d=%h rdy=%b cnt=%0d, want v=0 d=00 rdy=1 cnt=0",
               out_valid, out_data, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL clr_skid: got v=%b d=%h, want v=0 d=00", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int            bad = 0;
    logic          fin, fout;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          out_data !== ((q.size() > 0) ? q[0] : 8'h00)) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: got v=%b d=%h rdy=%b, want v=%b d=%h rdy=%b",
                   c, out_valid, out_data, in_ready, q.size() > 0,
                   (q.size() > 0) ? q[0] : 8'h00, q.size() < 2);
      end
      fin  = in_valid && (q.size() < 2);
      fout = out_ready && (q.size() > 0);
      tick();
      if (fout) void'(q.pop_front());
      if (fin) q.push_back(in_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got v=%b, want v=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate();
    test_clr_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
